// File: rtl/altpcie_phase_arb_pkg.sv
// Shared types and constants for the PLL phase-step arbiter.
// Holds the arbiter FSM state encoding, a constant-safe clog2 helper and
// the default parameter values used by altpcie_phase_step_arb.
`timescale 1ns/1ps
package altpcie_phase_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STEP   = 3'd1,
        WREL   = 3'd2,
        SETTLE = 3'd3,
        CMPL   = 3'd4
    } phase_state_e;

    localparam int DEF_NREQ       = 3;
    localparam int DEF_CNT_W      = 8;
    localparam int DEF_TIMEOUT    = 255;
    localparam int DEF_SETTLE_CYC = 4;
    localparam int DEF_POS_W      = 10;

    // Bits needed to hold values 0..value-1; never returns less than 1 so
    // that degenerate parameters still give a legal vector width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/altpcie_rr_arb.sv
// Combinational round-robin picker: returns the first asserted request at or
// after the rotation pointer (wrapping), as both one-hot and binary index.
`timescale 1ns/1ps
module altpcie_rr_arb #(
    parameter int NREQ  = 3,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    int w_pos;

    // Scan from the pointer upward, wrapping, and stop at the first request.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= NREQ) begin
                w_pos = w_pos - NREQ;
            end
            if (!o_any && i_req[w_pos]) begin
                o_any        = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = IDX_W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/altpcie_phase_step_arb.sv
// Round-robin owner arbitration for one PLL dynamic phase-shift port.
// The granted requester gets an N-step burst using the PhaseStep/PhaseDone
// handshake, with settle gaps between steps and a per-step timeout.
// Optional build macro PLL_PHASE_POS_TRACK_EN adds the POS_W parameter and a
// saturating signed net-position output phase_pos.
`timescale 1ns/1ps
module altpcie_phase_step_arb
    import altpcie_phase_arb_pkg::*;
#(
    parameter int NREQ       = DEF_NREQ,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
`ifdef PLL_PHASE_POS_TRACK_EN
    , parameter int POS_W    = DEF_POS_W
`endif
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       req_dir,
    input  logic [NREQ*CNT_W-1:0] req_cnt,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  err,
    output logic                  busy,
    output logic                  PhaseStep,
    output logic                  PhaseUpDown,
    input  logic                  PhaseDone
`ifdef PLL_PHASE_POS_TRACK_EN
    , output logic [POS_W-1:0]    phase_pos
`endif
);

    localparam int IDX_W = clog2(NREQ);
    localparam int TO_W  = clog2(TIMEOUT + 1);
    localparam int ST_W  = clog2(SETTLE_CYC + 1);

    localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT - 1);
    localparam logic [ST_W-1:0]  SETTLE_LAST = ST_W'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);
    localparam logic [IDX_W-1:0] OWNER_LAST  = IDX_W'(NREQ - 1);

    phase_state_e r_state;
    phase_state_e w_next;

    logic [NREQ-1:0]  w_arb_gnt;
    logic [IDX_W-1:0] w_arb_idx;
    logic             w_arb_any;
    logic [CNT_W-1:0] w_win_cnt;
    logic             w_owner_req;
    logic             w_start;

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_owner;
    logic [CNT_W-1:0] r_rem;
    logic [TO_W-1:0]  r_to_cnt;
    logic [ST_W-1:0]  r_settle_cnt;
    logic             r_err_q;

    logic [NREQ-1:0]  r_grant;
    logic [NREQ-1:0]  r_done;
    logic             r_err;
    logic             r_busy;
    logic             r_phase_step;
    logic             r_phase_updown;

    altpcie_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arb (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    assign w_win_cnt   = req_cnt[int'(w_arb_idx) * CNT_W +: CNT_W];
    assign w_owner_req = req[r_owner];
    assign w_start     = (r_state == IDLE) && (w_next != IDLE);

    // State register.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. Arbitration and the settle-to-step move wait for
    // PhaseDone high so a new strobe never lands on a step still in flight
    // (e.g. one left over from a reset mid-burst).
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_arb_any && PhaseDone) begin
                    w_next = (w_win_cnt == '0) ? CMPL : STEP;
                end
            end
            STEP: begin
                if (!PhaseDone) begin
                    w_next = WREL;
                end else if (r_to_cnt == TO_LAST) begin
                    w_next = CMPL;
                end
            end
            WREL: begin
                if (PhaseDone) begin
                    if ((r_rem == '0) || !w_owner_req) begin
                        w_next = CMPL;
                    end else if (SETTLE_CYC == 0) begin
                        w_next = STEP;
                    end else begin
                        w_next = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (!w_owner_req) begin
                    w_next = CMPL;
                end else if ((r_settle_cnt == SETTLE_LAST) && PhaseDone) begin
                    w_next = STEP;
                end
            end
            CMPL: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Burst bookkeeping: owner and step budget latched at grant, step budget
    // counted down on each accepted step, timeout and settle timers.
    always_ff @(posedge clock) begin
        if (w_start) begin
            r_owner <= w_arb_idx;
            r_rem   <= w_win_cnt;
        end else if ((r_state == STEP) && !PhaseDone) begin
            r_rem   <= r_rem - 1'b1;
        end

        if ((w_next == STEP) && (r_state != STEP)) begin
            r_to_cnt <= '0;
        end else if (r_state == STEP) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end

        if (r_state != SETTLE) begin
            r_settle_cnt <= '0;
        end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
        end
    end

    // Rotation pointer and timeout flag; the served owner drops to lowest
    // priority when its burst completes.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_ptr   <= '0;
            r_err_q <= 1'b0;
        end else begin
            if (r_state == CMPL) begin
                r_ptr   <= (r_owner == OWNER_LAST) ? '0 : r_owner + 1'b1;
                r_err_q <= 1'b0;
            end else if ((r_state == STEP) && (w_next == CMPL)) begin
                r_err_q <= 1'b1;
            end
        end
    end

    // Registered outputs. Direction is captured at grant and held for the
    // whole burst; grant is released together with the done/err pulse.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_grant        <= '0;
            r_done         <= '0;
            r_err          <= 1'b0;
            r_busy         <= 1'b0;
            r_phase_step   <= 1'b0;
            r_phase_updown <= 1'b0;
        end else begin
            r_busy       <= (w_next != IDLE);
            r_phase_step <= (w_next == STEP);
            r_done       <= (r_state == CMPL) ? r_grant : '0;
            r_err        <= (r_state == CMPL) && r_err_q;
            if (w_start) begin
                r_grant        <= w_arb_gnt;
                r_phase_updown <= req_dir[w_arb_idx];
            end else if (r_state == CMPL) begin
                r_grant        <= '0;
            end
        end
    end

    assign grant       = r_grant;
    assign done        = r_done;
    assign err         = r_err;
    assign busy        = r_busy;
    assign PhaseStep   = r_phase_step;
    assign PhaseUpDown = r_phase_updown;

`ifdef PLL_PHASE_POS_TRACK_EN
    localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
    localparam logic signed [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};

    logic signed [POS_W-1:0] r_pos;

    // One step up or down, clamped at the signed range limits.
    function automatic logic signed [POS_W-1:0] pos_step(
        input logic signed [POS_W-1:0] pos,
        input logic                    up
    );
        if (up) begin
            return (pos == POS_MAX) ? pos : pos + POS_ONE;
        end
        return (pos == POS_MIN) ? pos : pos - POS_ONE;
    endfunction

    // Net position moves only when the PLL accepts a step.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_pos <= '0;
        end else if ((r_state == STEP) && !PhaseDone) begin
            r_pos <= pos_step(r_pos, r_phase_updown);
        end
    end

    assign phase_pos = r_pos;
`endif

endmodule

// File: tb/tb_altpcie_phase_step_arb.sv
// Directed bench for altpcie_phase_step_arb with a small PLL handshake model,
// a negedge monitor and an auto-dropping requester model.
`timescale 1ns/1ps
module tb_altpcie_phase_step_arb;

    localparam int NREQ  = 3;
    localparam int CNT_W = 8;

    logic                  clock;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       req_dir;
    logic [NREQ*CNT_W-1:0] req_cnt;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  err;
    logic                  busy;
    logic                  PhaseStep;
    logic                  PhaseUpDown;
    logic                  PhaseDone;
`ifdef PLL_PHASE_POS_TRACK_EN
    logic [3:0]            phase_pos;
`endif

    altpcie_phase_step_arb #(
        .NREQ       (NREQ),
        .CNT_W      (CNT_W),
        .TIMEOUT    (255),
        .SETTLE_CYC (4)
`ifdef PLL_PHASE_POS_TRACK_EN
        , .POS_W    (4)
`endif
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .req         (req),
        .req_dir     (req_dir),
        .req_cnt     (req_cnt),
        .grant       (grant),
        .done        (done),
        .err         (err),
        .busy        (busy),
        .PhaseStep   (PhaseStep),
        .PhaseUpDown (PhaseUpDown),
        .PhaseDone   (PhaseDone)
`ifdef PLL_PHASE_POS_TRACK_EN
        , .phase_pos (phase_pos)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor state
    int   m_steps, m_step_high, m_falls, m_gap, m_min_gap;
    bit   m_gap_valid;
    int   m_dir_bad, m_proto_bad, m_grant_cyc;
    int   m_done_cnt [NREQ];
    int   m_done_total, m_err_done, m_err_alone, m_busy_at_done, m_pd_at_done;
    bit   m_exp_dir;
    int   m_order[$];
    logic m_prev_step;
    logic [NREQ-1:0] m_prev_grant;
    bit   auto_drop;
    bit   pll_stuck;

    task automatic clear_mon();
        m_steps = 0; m_step_high = 0; m_falls = 0; m_gap = 0; m_min_gap = 1000;
        m_gap_valid = 0; m_dir_bad = 0; m_proto_bad = 0; m_grant_cyc = 0;
        for (int i = 0; i < NREQ; i++) m_done_cnt[i] = 0;
        m_done_total = 0; m_err_done = 0; m_err_alone = 0;
        m_busy_at_done = 0; m_pd_at_done = 0;
        m_order.delete();
    endtask

    function automatic int order_at(input int k);
        return (k < m_order.size()) ? m_order[k] : -1;
    endfunction

    // PLL model: PhaseDone drops a cycle after the strobe is seen and returns
    // high three clocks later; in stuck mode it never responds.
    initial begin
        PhaseDone = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (!pll_stuck && PhaseStep && PhaseDone) begin
                @(posedge clock);
                #1 PhaseDone = 1'b0;
                repeat (3) @(posedge clock);
                #1 PhaseDone = 1'b1;
            end
        end
    end

    // Requester model: drop req in the same cycle the done pulse is seen.
    initial begin
        forever begin
            @(negedge clock);
            if (auto_drop) req = req & ~done;
        end
    end

    // Output monitor.
    initial begin
        m_prev_step  = 1'b0;
        m_prev_grant = '0;
        forever begin
            @(negedge clock);
            if (PhaseStep && !m_prev_step) begin
                m_steps++;
                if (m_gap_valid && (m_gap < m_min_gap)) m_min_gap = m_gap;
                if (!PhaseDone) m_proto_bad++;
            end
            if (PhaseStep) begin
                m_step_high++;
                if (PhaseUpDown !== m_exp_dir) m_dir_bad++;
            end
            if (!PhaseStep && m_prev_step) begin
                m_falls++;
                m_gap = 1;
                m_gap_valid = 1;
            end else if (!PhaseStep) begin
                m_gap++;
            end
            if (grant != '0) m_grant_cyc++;
            if ((grant != '0) && (m_prev_grant == '0)) begin
                for (int i = 0; i < NREQ; i++) if (grant[i]) m_order.push_back(i);
            end
            if (done != '0) begin
                for (int i = 0; i < NREQ; i++) if (done[i]) m_done_cnt[i]++;
                m_done_total++;
                if (err) m_err_done++;
                m_busy_at_done = busy;
                m_pd_at_done   = PhaseDone;
            end
            if (err && (done == '0)) m_err_alone++;
            m_prev_step  = PhaseStep;
            m_prev_grant = grant;
        end
    end

    task automatic start_req(input int idx, input logic dir, input int cnt);
        req_dir[idx] = dir;
        req_cnt[idx*CNT_W +: CNT_W] = CNT_W'(cnt);
        req[idx] = 1'b1;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while ((m_done_total < target) && (n < budget)) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 32'(m_done_total >= target), 1);
        repeat (2) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; req = '0; req_dir = '0; req_cnt = '0;
        auto_drop = 1'b1; pll_stuck = 1'b0; m_exp_dir = 1'b0;
        clear_mon();
        repeat (3) @(negedge clock);
        rst = 1'b0;
        @(negedge clock);

        chk("rst_grant", 32'(grant), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_step", 32'(PhaseStep), 0);
        chk("rst_updown", 32'(PhaseUpDown), 0);

        // Single requester, 3 down-steps.
        clear_mon(); m_exp_dir = 1'b0;
        start_req(0, 1'b0, 3);
        wait_done(1, 400, "t1_wait");
        chk("t1_steps", 32'(m_steps), 3);
        chk("t1_dir_bad", 32'(m_dir_bad), 0);
        chk("t1_gap_ge_settle", 32'(m_min_gap >= 4), 1);
        chk("t1_done0", 32'(m_done_cnt[0]), 1);
        chk("t1_err", 32'(m_err_done), 0);
        chk("t1_proto", 32'(m_proto_bad), 0);

        // Three simultaneous requests from pointer 0.
        do_reset();
        clear_mon(); m_exp_dir = 1'b1;
        start_req(0, 1'b1, 1); start_req(1, 1'b1, 1); start_req(2, 1'b1, 1);
        wait_done(3, 600, "t2_wait");
        chk("t2_order0", 32'(order_at(0)), 0);
        chk("t2_order1", 32'(order_at(1)), 1);
        chk("t2_order2", 32'(order_at(2)), 2);
        chk("t2_steps", 32'(m_steps), 3);

        // Zero-count request after reset, then rotation from pointer 2.
        do_reset();
        clear_mon();
        start_req(1, 1'b1, 0);
        wait_done(1, 100, "t3_wait");
        chk("t3_grant_cyc", 32'(m_grant_cyc), 1);
        chk("t3_done1", 32'(m_done_cnt[1]), 1);
        chk("t3_steps", 32'(m_steps), 0);
        start_req(0, 1'b1, 1); start_req(2, 1'b1, 1);
        wait_done(3, 600, "t3b_wait");
        chk("t3_order1", 32'(order_at(1)), 2);
        chk("t3_order2", 32'(order_at(2)), 0);

        // PhaseDone stuck high: timeout.
        clear_mon(); m_exp_dir = 1'b0; pll_stuck = 1'b1;
        start_req(0, 1'b0, 1);
        wait_done(1, 600, "t4_wait");
        chk("t4_step_high", 32'(m_step_high), 255);
        chk("t4_steps", 32'(m_steps), 1);
        chk("t4_err_with_done", 32'(m_err_done), 1);
        chk("t4_err_alone", 32'(m_err_alone), 0);
        chk("t4_busy_at_done", 32'(m_busy_at_done), 0);
        pll_stuck = 1'b0;

        // Drop request after the second accepted step.
        clear_mon(); m_exp_dir = 1'b1;
        start_req(0, 1'b1, 10);
        n = 0;
        while ((m_falls < 2) && (n < 200)) begin
            @(negedge clock);
            n++;
        end
        chk("t5_two_falls", 32'(m_falls >= 2), 1);
        req[0] = 1'b0;
        wait_done(1, 200, "t5_wait");
        chk("t5_steps", 32'(m_steps), 2);
        chk("t5_done0", 32'(m_done_cnt[0]), 1);
        chk("t5_pd_at_done", 32'(m_pd_at_done), 1);
        chk("t5_err", 32'(m_err_done), 0);

`ifdef PLL_PHASE_POS_TRACK_EN
        // Saturating position: 10 up with POS_W=4 clamps at 7, then 3 down.
        do_reset();
        chk("t6_pos_rst", 32'(phase_pos), 0);
        clear_mon(); m_exp_dir = 1'b1;
        start_req(1, 1'b1, 10);
        wait_done(1, 400, "t6_up_wait");
        chk("t6_pos_up", 32'(phase_pos), 7);
        clear_mon(); m_exp_dir = 1'b0;
        start_req(1, 1'b0, 3);
        wait_done(1, 200, "t6_dn_wait");
        chk("t6_pos_dn", 32'(phase_pos), 4);
`endif

        // Reset in the middle of a burst.
        clear_mon(); m_exp_dir = 1'b1;
        start_req(0, 1'b1, 10);
        n = 0;
        while (!((m_falls >= 1) && PhaseStep) && (n < 200)) begin
            @(negedge clock);
            n++;
        end
        chk("t7_mid_burst", 32'(PhaseStep), 1);
        rst = 1'b1;
        req = '0;
        @(negedge clock);
        chk("t7_grant", 32'(grant), 0);
        chk("t7_busy", 32'(busy), 0);
        chk("t7_step", 32'(PhaseStep), 0);
        chk("t7_updown", 32'(PhaseUpDown), 0);
        chk("t7_done", 32'(done), 0);
        chk("t7_err", 32'(err), 0);
`ifdef PLL_PHASE_POS_TRACK_EN
        chk("t7_pos", 32'(phase_pos), 0);
`endif
        rst = 1'b0;
        n = 0;
        while (!PhaseDone && (n < 20)) begin
            @(negedge clock);
            n++;
        end
        chk("t7_pll_idle", 32'(PhaseDone), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
